// File: rtl/rx_timer.sv
// rtl/rx_timer.sv - USB full-speed receive bit timing, bit unstuffing and byte framing
//
// Re-aligns a CLKS_PER_BIT phase counter on every line edge, strobes the
// shift register once per data bit at the mid-bit sample point, drops
// stuffed bits and flags a byte boundary after every BITS_PER_BYTE data bits.
//
// Ports:
//   clk           in   system clock (8x the line bit rate)
//   n_rst         in   asynchronous active-low reset
//   rcving        in   receive window; low holds the block idle
//   d_edge        in   one-cycle pulse on any D+/D- transition
//   d_orig        in   NRZI-decoded bit, valid at the sample point
//   shift_enable  out  one-cycle strobe, shift register captures d_orig
//   byte_received out  one-cycle pulse, a full byte is in the shift register
//   stuff_err     out  one-cycle pulse, a stuffed-bit position held a 1

module rx_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_PHASE  = 3,
    parameter int BITS_PER_BYTE = 8,
    parameter int STUFF_LIMIT   = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);
    localparam logic [OW-1:0] ONES_LIMIT   = OW'(STUFF_LIMIT);

    logic [PW-1:0] phase;
    logic [BW-1:0] bit_cnt;
    logic [OW-1:0] ones_cnt;

    logic sample;
    logic data_bit;
    logic stuffed;

    // The sample decision uses the registered phase, so an edge arriving in
    // the sample cycle re-aligns the counter without cancelling this sample.
    always_comb begin
        sample       = rcving && (phase == PHASE_SAMPLE);
        data_bit     = sample && (ones_cnt < ONES_LIMIT);
        stuffed      = sample && (ones_cnt == ONES_LIMIT);
        shift_enable = data_bit;
    end

    // The edge cycle itself is phase 0, hence the reload value of 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (!rcving) begin
            phase <= '0;
        end else if (d_edge) begin
            phase <= PW'(1);
        end else if (phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    // Only data bits advance the byte position; stuffed bits are invisible.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (!rcving) begin
            bit_cnt <= '0;
        end else if (data_bit) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
        end
    end

    // Run length of decoded 1s; reaching STUFF_LIMIT marks the next bit as stuffed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt <= '0;
        end else if (!rcving) begin
            ones_cnt <= '0;
        end else if (stuffed) begin
            ones_cnt <= '0;
        end else if (data_bit) begin
            ones_cnt <= d_orig ? ones_cnt + OW'(1) : '0;
        end
    end

    // Not gated by rcving so a byte completed just before the window closes
    // is still reported.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_received <= 1'b0;
            stuff_err     <= 1'b0;
        end else begin
            byte_received <= data_bit && (bit_cnt == BIT_LAST);
            stuff_err     <= stuffed && d_orig;
        end
    end

endmodule

// File: tb/tb_rx_timer.sv
// tb/tb_rx_timer.sv - self-checking scoreboard bench for rx_timer
`timescale 1ns/1ps

module tb_rx_timer;

    localparam int SAMPLE_PHASE  = 3;
    localparam int STUFF_LIMIT   = 6;
    localparam int BITS_PER_BYTE = 8;

    logic clk = 1'b0;
    logic n_rst;
    logic rcving;
    logic d_edge;
    logic d_orig;
    logic shift_enable;
    logic byte_received;
    logic stuff_err;

    rx_timer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rcving       (rcving),
        .d_edge       (d_edge),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int se_q[$];
    int br_q[$];
    int err_q[$];
    logic prev_se = 1'b0;
    logic prev_br = 1'b0;
    logic prev_err = 1'b0;
    int se_seen = 0;
    int br_seen = 0;
    int err_seen = 0;
    int m_ones = 0;
    int m_bits = 0;

    // Pops the expected cycle of each observed pulse and checks pulse width.
    task automatic sb_sample();
        int e;
        if (shift_enable === 1'b1) begin
            se_seen++;
            checks++;
            if (se_q.size() == 0) begin
                $display("FAIL se_unexpected: shift_enable at cycle %0d, none expected", cyc);
            end else begin
                e = se_q.pop_front();
                if (e !== cyc) $display("FAIL se_cycle: got cycle %0d, expected %0d", cyc, e);
                else passes++;
            end
            checks++;
            if (prev_se === 1'b1) $display("FAIL se_width: high 2 cycles at %0d, expected 1", cyc);
            else passes++;
        end
        if (byte_received === 1'b1) begin
            br_seen++;
            checks++;
            if (br_q.size() == 0) begin
                $display("FAIL br_unexpected: byte_received at cycle %0d, none expected", cyc);
            end else begin
                e = br_q.pop_front();
                if (e !== cyc) $display("FAIL br_cycle: got cycle %0d, expected %0d", cyc, e);
                else passes++;
            end
            checks++;
            if (prev_br === 1'b1) $display("FAIL br_width: high 2 cycles at %0d, expected 1", cyc);
            else passes++;
        end
        if (stuff_err === 1'b1) begin
            err_seen++;
            checks++;
            if (err_q.size() == 0) begin
                $display("FAIL err_unexpected: stuff_err at cycle %0d, none expected", cyc);
            end else begin
                e = err_q.pop_front();
                if (e !== cyc) $display("FAIL err_cycle: got cycle %0d, expected %0d", cyc, e);
                else passes++;
            end
            checks++;
            if (prev_err === 1'b1) $display("FAIL err_width: high 2 cycles at %0d, expected 1", cyc);
            else passes++;
        end
        prev_se  = shift_enable;
        prev_br  = byte_received;
        prev_err = stuff_err;
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One line bit: edge now, d_orig held for the whole bit. Expectations
    // come from the receive rules: sample SAMPLE_PHASE cycles after the edge,
    // stuffed bit after STUFF_LIMIT ones, byte pulse the cycle after the 8th.
    task automatic send_bit(input logic b, input int period);
        int t;
        rcving = 1'b1;
        d_edge = 1'b1;
        d_orig = b;
        t = cyc;
        if (m_ones == STUFF_LIMIT) begin
            if (b) err_q.push_back(t + SAMPLE_PHASE + 1);
            m_ones = 0;
        end else begin
            se_q.push_back(t + SAMPLE_PHASE);
            m_ones = b ? m_ones + 1 : 0;
            m_bits++;
            if (m_bits == BITS_PER_BYTE) begin
                br_q.push_back(t + SAMPLE_PHASE + 1);
                m_bits = 0;
            end
        end
        step();
        d_edge = 1'b0;
        repeat (period - 1) step();
    endtask

    // LSB first, with a stuffed 0 inserted wherever the line requires one.
    task automatic send_byte(input logic [7:0] data, input int last_period);
        for (int i = 0; i < 8; i++) begin
            if (m_ones == STUFF_LIMIT) send_bit(1'b0, 8);
            send_bit(data[i], (i == 7) ? last_period : 8);
        end
    endtask

    task automatic rx_stop();
        rcving = 1'b0;
        d_edge = 1'b0;
        d_orig = 1'b0;
        m_ones = 0;
        m_bits = 0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        rcving = 1'b0;
        d_edge = 1'b0;
        d_orig = 1'b0;
        repeat (3) step();
        checks++;
        if ({shift_enable, byte_received, stuff_err} !== 3'b000)
            $display("FAIL reset_outputs: got %b, expected 000", {shift_enable, byte_received, stuff_err});
        else passes++;
        n_rst = 1'b1;
        step();
        send_bit(1'b0, 8);
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        step();
        n_rst = 1'b0;
        rcving = 1'b0;
        #1;
        checks++;
        if ({shift_enable, byte_received, stuff_err} !== 3'b000)
            $display("FAIL reset_midcount: got %b, expected 000", {shift_enable, byte_received, stuff_err});
        else passes++;
        m_ones = 0;
        m_bits = 0;
        repeat (2) step();
        n_rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            d_edge = i[0];
            d_orig = 1'b1;
            step();
        end
        d_edge = 1'b0;
        checks++;
        if (se_seen !== 1)
            $display("FAIL idle_strobes: got %0d strobes, expected 1", se_seen);
        else passes++;
        checks++;
        if (se_q.size() + br_q.size() + err_q.size() !== 0)
            $display("FAIL reset_missing: %0d expected pulses not seen, expected 0", se_q.size() + br_q.size() + err_q.size());
        else passes++;
    endtask

    task automatic test_single_bit();
        int t;
        int s0;
        s0 = se_seen;
        rcving = 1'b1;
        d_edge = 1'b1;
        d_orig = 1'b0;
        t = cyc;
        se_q.push_back(t + 3);
        se_q.push_back(t + 11);
        se_q.push_back(t + 19);
        step();
        d_edge = 1'b0;
        repeat (19) step();
        rx_stop();
        checks++;
        if (se_seen - s0 !== 3)
            $display("FAIL single_count: got %0d strobes, expected 3", se_seen - s0);
        else passes++;
        checks++;
        if (se_q.size() !== 0)
            $display("FAIL single_missing: %0d strobes not seen, expected 0", se_q.size());
        else passes++;
    endtask

    task automatic test_byte();
        int s0;
        int b0;
        s0 = se_seen;
        b0 = br_seen;
        send_byte(8'h5A, 8);
        rx_stop();
        checks++;
        if (se_seen - s0 !== 8) $display("FAIL byte_strobes: got %0d, expected 8", se_seen - s0);
        else passes++;
        checks++;
        if (br_seen - b0 !== 1) $display("FAIL byte_pulses: got %0d, expected 1", br_seen - b0);
        else passes++;
        checks++;
        if (se_q.size() + br_q.size() !== 0)
            $display("FAIL byte_missing: %0d pulses not seen, expected 0", se_q.size() + br_q.size());
        else passes++;
    endtask

    task automatic test_resync();
        int periods[8] = '{8, 7, 9, 8, 7, 9, 9, 7};
        logic [7:0] data;
        int s0;
        int b0;
        data = 8'hC3;
        s0 = se_seen;
        b0 = br_seen;
        for (int i = 0; i < 8; i++) send_bit(data[i], periods[i]);
        rx_stop();
        checks++;
        if (se_seen - s0 !== 8) $display("FAIL resync_strobes: got %0d, expected 8", se_seen - s0);
        else passes++;
        checks++;
        if (br_seen - b0 !== 1) $display("FAIL resync_pulses: got %0d, expected 1", br_seen - b0);
        else passes++;
        checks++;
        if (se_q.size() + br_q.size() !== 0)
            $display("FAIL resync_missing: %0d pulses not seen, expected 0", se_q.size() + br_q.size());
        else passes++;
    endtask

    task automatic test_stuffing();
        int s0;
        int b0;
        int e0;
        s0 = se_seen;
        b0 = br_seen;
        e0 = err_seen;
        repeat (6) send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        rx_stop();
        checks++;
        if (se_seen - s0 !== 8) $display("FAIL stuff0_strobes: got %0d, expected 8", se_seen - s0);
        else passes++;
        checks++;
        if (err_seen - e0 !== 0) $display("FAIL stuff0_err: got %0d, expected 0", err_seen - e0);
        else passes++;
        checks++;
        if (br_seen - b0 !== 1) $display("FAIL stuff0_pulses: got %0d, expected 1", br_seen - b0);
        else passes++;
        e0 = err_seen;
        repeat (6) send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        rx_stop();
        checks++;
        if (err_seen - e0 !== 1) $display("FAIL stuff1_err: got %0d, expected 1", err_seen - e0);
        else passes++;
        checks++;
        if (se_q.size() + br_q.size() + err_q.size() !== 0)
            $display("FAIL stuff_missing: %0d pulses not seen, expected 0", se_q.size() + br_q.size() + err_q.size());
        else passes++;
    endtask

    task automatic test_abort();
        int s0;
        int b0;
        b0 = br_seen;
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        rx_stop();
        checks++;
        if (br_seen - b0 !== 0) $display("FAIL abort_partial: got %0d byte pulses, expected 0", br_seen - b0);
        else passes++;
        s0 = se_seen;
        b0 = br_seen;
        send_byte(8'hFF, 8);
        send_byte(8'h00, 4);
        rx_stop();
        checks++;
        if (se_seen - s0 !== 16) $display("FAIL abort_strobes: got %0d, expected 16", se_seen - s0);
        else passes++;
        checks++;
        if (br_seen - b0 !== 2) $display("FAIL abort_pulses: got %0d, expected 2", br_seen - b0);
        else passes++;
        checks++;
        if (se_q.size() + br_q.size() + err_q.size() !== 0)
            $display("FAIL abort_missing: %0d pulses not seen, expected 0", se_q.size() + br_q.size() + err_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_byte();
        test_resync();
        test_stuffing();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
